hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the RISCV16 five-stage core. It detects load-use hazards, which forwarding cannot cover, and inserts one bubble for each. It flushes wrong-path instructions on a taken branch or jump resolved in EX. It freezes the pipeline while the data memory withholds `dmem_ready`, latches a sticky error on a memory timeout, and counts stall cycles for performance monitoring.

---
 rtl/riscv16_ctrl_pkg.sv | 44 ++++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv16_ctrl_pkg.sv
// Shared control definitions for the RISCV16 pipeline sequencing logic.
package riscv16_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned STATE_W    = 2;
  localparam int unsigned STALL_W    = 16;

  typedef logic [STATE_W-1:0]    state_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam state_t    ST_RUN      = 2'd0;
  localparam state_t    ST_MEM_WAIT = 2'd1;
  localparam state_t    ST_ERR      = 2'd2;
  localparam reg_addr_t REG_ZERO    = 4'd0;

  // Pipeline register enables/flushes driven by the hazard controller.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_write;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_FREEZE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_BRANCH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_LOADUSE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_RESET   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // A load in EX whose destination is read by the instruction in ID.
  function automatic logic load_use_hazard(
    input logic      mem_read,
    input reg_addr_t rd,
    input reg_addr_t rs1,
    input reg_addr_t rs2,
    input logic      use_rs2
  );
    return mem_read && (rd != REG_ZERO) &&
           ((rd == rs1) || (use_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive data-memory freeze cycles and flags the timeout limit.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic expired
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

  logic [TW-1:0] cnt;

  // Load 1 on wait entry, count up while the freeze persists; never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(1);
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expired = (cnt == TW'(MEM_TIMEOUT));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use bubbles, branch flushes, memory freeze and timeout.
module hazard_ctrl
  import riscv16_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] IFID_RS1,
  input  logic [REG_ADDR_W-1:0] IFID_RS2,
  input  logic                  IFID_useRS2,
  input  logic [REG_ADDR_W-1:0] IDEX_RD,
  input  logic                  IDEX_memRead,
  input  logic                  EX_branchTaken,
  input  logic                  EXMEM_memReq,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  IFID_write,
  output logic                  IFID_flush,
  output logic                  IDEX_flush,
  output logic                  EXMEM_write,
  output logic                  MEMWB_bubble,
  output logic [STALL_W-1:0]    stall_count,
  output logic                  mem_timeout
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   freeze;
  logic   loaduse;
  logic   timer_load;
  logic   timer_inc;
  logic   timer_expired;

  assign freeze  = EXMEM_memReq && !dmem_ready;
  assign loaduse = load_use_hazard(IDEX_memRead, IDEX_RD, IFID_RS1, IFID_RS2, IFID_useRS2);

  assign timer_load = !rst && (state_q == ST_RUN) && freeze;
  assign timer_inc  = !rst && (state_q == ST_MEM_WAIT) && freeze;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ERR is only left through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (freeze) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (!freeze)           state_d = ST_RUN;
        else if (timer_expired) state_d = ST_ERR;
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_RUN;
    endcase
  end

  // Output mux: reset, then freeze/ERR, then branch, then load-use, then normal.
  always_comb begin
    ctrl = CTRL_NORMAL;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else if (state_q == ST_ERR) begin
      ctrl = CTRL_FREEZE;
    end else if (freeze) begin
      ctrl = CTRL_FREEZE;
    end else if (EX_branchTaken) begin
      ctrl = CTRL_BRANCH;
    end else if (loaduse) begin
      ctrl = CTRL_LOADUSE;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign IFID_write   = ctrl.ifid_write;
  assign IFID_flush   = ctrl.ifid_flush;
  assign IDEX_flush   = ctrl.idex_flush;
  assign EXMEM_write  = ctrl.exmem_write;
  assign MEMWB_bubble = ctrl.memwb_bubble;

  // Saturating stall counter; cycles spent in ERR are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if ((state_q != ST_ERR) && !ctrl.pc_write && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_W'(1);
    end
  end

  // Sticky timeout flag, raised the cycle after ERR is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_timeout <= 1'b0;
    end else if (state_q == ST_ERR) begin
      mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with a short memory timeout.
module tb_hazard_ctrl;

  localparam int unsigned TIMEOUT = 4;

  // Expected {pc_write, IFID_write, IFID_flush, IDEX_flush, EXMEM_write, MEMWB_bubble}
  localparam logic [5:0] O_NORMAL  = 6'b110010;
  localparam logic [5:0] O_FREEZE  = 6'b000001;
  localparam logic [5:0] O_BRANCH  = 6'b111110;
  localparam logic [5:0] O_LOADUSE = 6'b000110;
  localparam logic [5:0] O_RESET   = 6'b001101;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ifid_rs1, ifid_rs2, idex_rd;
  logic        ifid_use_rs2, idex_mem_read, ex_branch_taken, exmem_mem_req, dmem_ready;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_bubble;
  logic [15:0] stall_count;
  logic        mem_timeout;

  int checks = 0;
  int passed = 0;

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .IFID_RS1       (ifid_rs1),
    .IFID_RS2       (ifid_rs2),
    .IFID_useRS2    (ifid_use_rs2),
    .IDEX_RD        (idex_rd),
    .IDEX_memRead   (idex_mem_read),
    .EX_branchTaken (ex_branch_taken),
    .EXMEM_memReq   (exmem_mem_req),
    .dmem_ready     (dmem_ready),
    .pc_write       (pc_write),
    .IFID_write     (ifid_write),
    .IFID_flush     (ifid_flush),
    .IDEX_flush     (idex_flush),
    .EXMEM_write    (exmem_write),
    .MEMWB_bubble   (memwb_bubble),
    .stall_count    (stall_count),
    .mem_timeout    (mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [5:0] exp);
    chk(tag, 32'({pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_bubble}),
        32'(exp));
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    chk(tag, 32'(dut.state_q), 32'(exp));
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifid_rs1 = 4'd0; ifid_rs2 = 4'd0; ifid_use_rs2 = 1'b0;
    idex_rd = 4'd0; idex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    exmem_mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    chk_out("reset_outputs", O_RESET);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_stall", 32'(stall_count), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    chk_state("reset_state", S_RUN);
    chk_out("idle_normal", O_NORMAL);

    // Load-use on RS1: one bubble, counted on the next edge
    idex_mem_read = 1'b1; idex_rd = 4'd3; ifid_rs1 = 4'd3;
    #1;
    chk_out("loaduse_rs1", O_LOADUSE);
    chk("loaduse_stall_before", 32'(stall_count), 32'd0);
    tick();
    chk("loaduse_stall_after", 32'(stall_count), 32'd1);
    idle_inputs();
    #1;
    chk_out("loaduse_released", O_NORMAL);

    // Destination x0 never stalls
    idex_mem_read = 1'b1; idex_rd = 4'd0; ifid_rs1 = 4'd0;
    #1;
    chk_out("loaduse_x0", O_NORMAL);
    // RS2 match ignored when RS2 is not read, stalls when it is
    idex_rd = 4'd3; ifid_rs1 = 4'd5; ifid_rs2 = 4'd3; ifid_use_rs2 = 1'b0;
    #1;
    chk_out("loaduse_rs2_unused", O_NORMAL);
    ifid_use_rs2 = 1'b1;
    #1;
    chk_out("loaduse_rs2_used", O_LOADUSE);

    // Taken branch wins over a simultaneous load-use
    ex_branch_taken = 1'b1;
    #1;
    chk_out("branch_over_loaduse", O_BRANCH);
    tick();
    chk("branch_stall_unchanged", 32'(stall_count), 32'd1);
    idle_inputs();

    // Three cycles of dmem_ready low, then release
    exmem_mem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    #1;
    chk_out("freeze_c0_branch_ignored", O_FREEZE);
    tick();
    chk_state("freeze_in_wait", S_WAIT);
    chk_out("freeze_c1", O_FREEZE);
    tick();
    chk_out("freeze_c2", O_FREEZE);
    tick();
    dmem_ready = 1'b1;
    #1;
    chk_out("freeze_release_branch", O_BRANCH);
    tick();
    chk_state("freeze_back_to_run", S_RUN);
    chk("freeze_stall_count", 32'(stall_count), 32'd4);

    // Ready on the first cycle: no stall, no wait state
    ex_branch_taken = 1'b0;
    #1;
    chk_out("ready_first_cycle", O_NORMAL);
    tick();
    chk_state("ready_first_state", S_RUN);
    chk("ready_first_stall", 32'(stall_count), 32'd4);

    // Timeout: 5 freeze cycles reach ERR, flag rises one cycle later
    dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_out("timeout_freeze", O_FREEZE);
      tick();
    end
    chk_state("timeout_err", S_ERR);
    chk("timeout_flag_not_yet", 32'(mem_timeout), 32'd0);
    chk("timeout_stall", 32'(stall_count), 32'd9);
    tick();
    chk("timeout_flag_set", 32'(mem_timeout), 32'd1);
    chk("err_stall_frozen", 32'(stall_count), 32'd9);
    dmem_ready = 1'b1;
    #1;
    chk_out("err_ignores_ready", O_FREEZE);
    tick();
    chk_state("err_sticky_state", S_ERR);
    chk("err_sticky_flag", 32'(mem_timeout), 32'd1);

    // Reset out of ERR
    rst = 1'b1;
    #1;
    chk_out("err_reset_outputs", O_RESET);
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    chk_state("err_reset_state", S_RUN);
    chk("err_reset_flag", 32'(mem_timeout), 32'd0);
    chk("err_reset_stall", 32'(stall_count), 32'd0);
    chk_out("err_reset_normal", O_NORMAL);

    // Reset in the middle of a memory wait
    exmem_mem_req = 1'b1; dmem_ready = 1'b0;
    tick();
    tick();
    chk_state("midwait_state", S_WAIT);
    rst = 1'b1;
    #1;
    chk_out("midwait_reset_outputs", O_RESET);
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    chk_out("midwait_after_reset", O_NORMAL);
    chk_state("midwait_reset_state", S_RUN);
    chk("midwait_reset_stall", 32'(stall_count), 32'd0);

    // Continuous load-use for 70000 cycles saturates the stall counter
    idex_mem_read = 1'b1; idex_rd = 4'd3; ifid_rs1 = 4'd3;
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_saturated", 32'(stall_count), 32'h0000_FFFF);
    tick();
    chk("stall_no_wrap", 32'(stall_count), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
